// File: rtl/load_store_unit_if.sv
// Request/response channel (requester <-> LSU) and memory port (LSU <-> memory)
// for the load/store unit.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport master (output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_fault);
  modport slave  (input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_fault);
endinterface

interface lsu_mem_if;
  logic [63:0] mem_address;
  logic [63:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] read_data;

  modport master (output mem_address, write_data, mem_write, mem_read, input read_data);
  modport slave  (input mem_address, write_data, mem_write, mem_read, output read_data);
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit on a 64-bit byte-addressed memory port.
// Define LSU_MISALIGN_CHECK_EN to fault on accesses not aligned to their size.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
  } lsu_req_t;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  state_t      state, nxt;
  lsu_req_t    rq;
  logic [63:0] merge_q, rdata_q;
  logic        fault_q;
  logic        fault, full_st;
  logic [63:0] mask, ext;
  logic [63:0] rd;

  assign rd      = mem.read_data;
  assign full_st = rq.write && (rq.size == 2'd3);

  always_comb begin
    mask = '1;
    ext  = rd;
    case (rq.size)
      2'd0: begin
        mask = 64'h0000_0000_0000_00ff;
        ext  = rq.uns ? {56'b0, rd[7:0]} : {{56{rd[7]}}, rd[7:0]};
      end
      2'd1: begin
        mask = 64'h0000_0000_0000_ffff;
        ext  = rq.uns ? {48'b0, rd[15:0]} : {{48{rd[15]}}, rd[15:0]};
      end
      2'd2: begin
        mask = 64'h0000_0000_ffff_ffff;
        ext  = rq.uns ? {32'b0, rd[31:0]} : {{32{rd[31]}}, rd[31:0]};
      end
      default: begin
        mask = '1;
        ext  = rd;
      end
    endcase
  end

  // Unsigned compare: addresses near 2^64 fault rather than wrapping.
`ifdef LSU_MISALIGN_CHECK_EN
  logic [2:0] align;
  always_comb begin
    case (rq.size)
      2'd0:    align = 3'b000;
      2'd1:    align = 3'b001;
      2'd2:    align = 3'b011;
      default: align = 3'b111;
    endcase
  end
  assign fault = (rq.addr > MAX_ADDR) || (|(rq.addr[2:0] & align));
`else
  assign fault = (rq.addr > MAX_ADDR);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req.req_valid) nxt = ACCESS;
      ACCESS:  nxt = (fault || !rq.write || full_st) ? RESP : WRITE;
      WRITE:   nxt = RESP;
      default: nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset kills them within the cycle.
  always_comb begin
    req.req_ready   = (state == IDLE);
    req.resp_valid  = (state == RESP);
    mem.mem_address = '0;
    mem.write_data  = '0;
    mem.mem_write   = 1'b0;
    mem.mem_read    = 1'b0;
    case (state)
      ACCESS: if (!fault) begin
        mem.mem_address = rq.addr;
        if (full_st) begin
          mem.mem_write  = 1'b1;
          mem.write_data = rq.wdata;
        end else begin
          mem.mem_read = 1'b1;
        end
      end
      WRITE: begin
        mem.mem_address = rq.addr;
        mem.mem_write   = 1'b1;
        mem.write_data  = merge_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rq      <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state == IDLE && req.req_valid) begin
        rq.write <= req.req_write;
        rq.size  <= req.req_size;
        rq.uns   <= req.req_unsigned;
        rq.addr  <= req.req_addr;
        rq.wdata <= req.req_wdata;
      end
      if (state == ACCESS) begin
        fault_q <= fault;
        rdata_q <= (fault || rq.write) ? '0 : ext;
        merge_q <= (rd & ~mask) | (rq.wdata & mask);
      end
    end
  end

  assign req.resp_rdata = rdata_q;
  assign req.resp_fault = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 64-byte behavioural memory.
module tb_load_store_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lsu_req_if rq();
  lsu_mem_if mb();

  load_store_unit #(.MEM_BYTES(64)) dut (.clock(clock), .reset_n(reset_n), .req(rq), .mem(mb));

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sbq[$];
  int checks = 0, failures = 0;
  int since = 0, nrd = 0, nwr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [7:0]  mem_arr [0:63];
  logic [63:0] rd;
  always_comb begin
    rd = '0;
    for (int i = 0; i < 8; i++)
      if (mb.mem_address + 64'(i) < 64'd64) rd[8*i +: 8] = mem_arr[int'(mb.mem_address) + i];
  end
  assign mb.read_data = rd;

  always @(posedge clock)
    if (mb.mem_write)
      for (int i = 0; i < 8; i++)
        if (mb.mem_address + 64'(i) < 64'd64) mem_arr[int'(mb.mem_address) + i] = mb.write_data[8*i +: 8];

  function automatic logic [63:0] get_dw(input int a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem_arr[a + i];
    return v;
  endfunction

  task automatic set_dw(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem_arr[a + i] = v[8*i +: 8];
  endtask

  // Cycles and strobes since the accept edge.
  always @(posedge clock) begin
    if (rq.req_valid && rq.req_ready) begin
      since <= 0; nrd <= 0; nwr <= 0;
    end else begin
      since <= since + 1;
      nrd   <= nrd + int'(mb.mem_read);
      nwr   <= nwr + int'(mb.mem_write);
    end
  end

  always @(negedge clock) begin
    if (reset_n && rq.resp_valid) begin
      if (sbq.size() == 0) chk("unexp_resp", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rdata", rq.resp_rdata, e.rdata);
        chk("fault", rq.resp_fault, e.fault);
        chk("latency", since + 1, e.lat);
        chk("n_read", nrd, e.nrd);
        chk("n_write", nwr, e.nwr);
        chk("excl", mb.mem_read & mb.mem_write, 0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] er, input logic ef,
                        input int lat, input int erd, input int ewr);
    exp_t e;
    int n;
    e.rdata = er; e.fault = ef; e.lat = lat; e.nrd = erd; e.nwr = ewr;
    @(negedge clock);
    n = 0;
    while (!rq.req_ready && n < 20) begin @(negedge clock); n++; end
    sbq.push_back(e);
    rq.req_valid = 1'b1; rq.req_write = w; rq.req_size = sz;
    rq.req_unsigned = u; rq.req_addr = a; rq.req_wdata = wd;
    @(negedge clock);
    rq.req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clock); n++; end
    if (sbq.size() != 0) begin
      chk("timeout", 64'(sbq.size()), 0);
      sbq.delete();
    end
  endtask

  initial begin
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_size = 2'd0;
    rq.req_unsigned = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
    for (int i = 0; i < 64; i++) mem_arr[i] = 8'h00;
    #1;
    chk("rst_ready", rq.req_ready, 1);
    chk("rst_resp_valid", rq.resp_valid, 0);
    chk("rst_rdata", rq.resp_rdata, 0);
    chk("rst_fault", rq.resp_fault, 0);
    chk("rst_strobes", {mb.mem_read, mb.mem_write}, 0);
    chk("rst_addr", mb.mem_address, 0);
    chk("rst_wdata", mb.write_data, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    mem_arr[8] = 8'h02;
    do_req(0, 3, 0, 64'd8, 0, 64'h2, 0, 2, 1, 0);
    mem_arr[16] = 8'hff;
    do_req(0, 0, 0, 64'd16, 0, 64'hffff_ffff_ffff_ffff, 0, 2, 1, 0);
    do_req(0, 0, 1, 64'd16, 0, 64'h0000_0000_0000_00ff, 0, 2, 1, 0);

    set_dw(16, 64'h0807_0605_0403_0201);
    do_req(1, 0, 0, 64'd17, 64'hab, 0, 0, 3, 1, 1);
    chk("sb_mem", get_dw(16), 64'h0807_0605_0403_ab01);

    do_req(1, 3, 0, 64'd56, 64'h1122_3344_5566_7788, 0, 0, 2, 0, 1);
    chk("sd_mem", get_dw(56), 64'h1122_3344_5566_7788);
    do_req(0, 3, 0, 64'd56, 0, 64'h1122_3344_5566_7788, 0, 2, 1, 0);

    do_req(0, 3, 0, 64'd57, 0, 0, 1, 2, 0, 0);
    do_req(0, 3, 0, 64'hffff_ffff_ffff_fff8, 0, 0, 1, 2, 0, 0);
    do_req(1, 3, 0, 64'd57, 64'hdead_beef_dead_beef, 0, 1, 2, 0, 0);
    chk("fault_no_write", get_dw(56), 64'h1122_3344_5566_7788);

    set_dw(0, 64'h8877_6655_4433_2211);
`ifdef LSU_MISALIGN_CHECK_EN
    do_req(0, 2, 0, 64'd2, 0, 0, 1, 2, 0, 0);
`else
    do_req(0, 2, 0, 64'd2, 0, 64'h0000_0000_6655_4433, 0, 2, 1, 0);
`endif
    do_req(0, 1, 0, 64'd6, 0, 64'hffff_ffff_ffff_8877, 0, 2, 1, 0);
    do_req(0, 2, 1, 64'd4, 0, 64'h0000_0000_8877_6655, 0, 2, 1, 0);
    do_req(0, 2, 0, 64'd4, 0, 64'hffff_ffff_8877_6655, 0, 2, 1, 0);
    do_req(1, 1, 0, 64'd0, 64'h1234_beef, 0, 0, 3, 1, 1);
    chk("sh_mem", get_dw(0), 64'h8877_6655_4433_beef);

    // Reset while the sw write-back is pending.
    set_dw(0, 64'h8877_6655_4433_2211);
    @(negedge clock);
    rq.req_valid = 1'b1; rq.req_write = 1'b1; rq.req_size = 2'd2;
    rq.req_unsigned = 1'b0; rq.req_addr = 64'd0; rq.req_wdata = 64'hdead_beef;
    @(negedge clock);
    rq.req_valid = 1'b0;
    @(negedge clock);
    chk("wr_strobe", mb.mem_write, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_wr_drop", mb.mem_write, 0);
    chk("rst_ready_imm", rq.req_ready, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk("rst_mem_kept", get_dw(0), 64'h8877_6655_4433_2211);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rst_no_resp", rq.resp_valid, 0);
    end
    chk("rst_ready_after", rq.req_ready, 1);
    chk("sb_empty", 64'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the byte-addressed 64-bit data memory port.
- Takes one load/store request at a time from the MEM pipeline stage and drives mem_address/write_data/mem_write/mem_read.
- Returns sign- or zero-extended load data.
- Sub-doubleword stores (sb/sh/sw) use a read-modify-write, because the memory always writes 8 bytes starting at mem_address.

Parameters:
- MEM_BYTES, 64, size of the attached memory in bytes; the highest legal access address is MEM_BYTES-8.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  input  1  loads only: zero-extend if 1, sign-extend if 0
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  64  extended load data; 0 for stores and faults
- resp_fault  output  1  access fault, valid with resp_valid
- mem_address  output  64  memory byte address
- write_data  output  64  memory write data
- mem_write  output  1  memory write strobe; memory writes on rising edge
- mem_read  output  1  memory read enable
- read_data  input  64  combinational memory read data, bytes at mem_address..+7, little-endian

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; req_ready=1.
  - resp_valid=0, resp_fault=0, resp_rdata=0.
  - mem_write=0, mem_read=0, mem_address=0, write_data=0.
  - All request registers cleared.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/size/unsigned/addr/wdata and go to ACCESS.
  - Memory outputs idle (strobes 0).
- ACCESS:
  - Fault check: fault if addr > MEM_BYTES-8; also misalignment when enabled (see Optional Feature).
  - On fault: no strobes; resp_fault=1, resp_rdata=0; go to RESP.
  - Load: mem_read=1, mem_address=addr. Capture read_data low 8·2^size bits, extended per unsigned, into resp_rdata. Go to RESP.
  - Store, size 3: mem_write=1, mem_address=addr, write_data=wdata (full write at this edge). Go to RESP.
  - Store, size 0..2: mem_read=1, mem_address=addr. Merge buffer = read_data with its low 8·2^size bits replaced by wdata's low bits. Go to WRITE.
- WRITE:
  - mem_write=1, mem_address=addr, write_data=merge buffer.
  - Bytes beyond the store size are rewritten unchanged. Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0. No backpressure.
  - Go to IDLE.
  - resp_rdata/resp_fault hold their value until the next request's ACCESS updates them.
- Latency from accept edge to resp_valid:
  - Load, sd, or fault: 2 cycles.
  - sb/sh/sw: 3 cycles.
- Single outstanding request. req_valid while not IDLE is ignored and not queued; the requester must hold it until req_ready=1.
- mem_read and mem_write are never both 1.
- Strobes are combinational decodes of the state registers, so they drop immediately on reset.
- Reset during WRITE:
  - Before the edge, no write occurs; memory retains its old contents.
  - The partial store is lost, with no response.
- Address arithmetic is full 64-bit. The range check uses unsigned compare, so addr near 2^64 faults (no wrap).

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: ACCESS also faults when addr is not a multiple of 2^size (half odd, word addr[1:0]≠0, double addr[2:0]≠0). Faulting accesses issue no memory strobes.
- Undefined: misaligned accesses are legal and performed at the given byte address; only the range check faults.

Test Plan:
- Memory preloaded with byte 2 at address 8 (rest of that doubleword 0); load size 3, addr 8 -> resp_valid 2 cycles after accept, resp_rdata=0x2, resp_fault=0, one mem_read cycle.
- Memory byte 0xFF at address 16; lb (unsigned=0) -> resp_rdata=0xFFFF_FFFF_FFFF_FFFF; same with lbu -> 0x0000_0000_0000_00FF.
- Memory addr 16..23 = 0x0807060504030201; sb wdata 0xAB at addr 17 -> 3-cycle latency; mem_read then mem_write cycle; memory 16..23 = 0x080706050403AB01.
- sd 0x1122334455667788 at addr 56 -> single mem_write cycle; subsequent ld 56 returns 0x1122334455667788.
- ld addr 57 (MEM_BYTES=64) -> resp_fault=1, resp_rdata=0, no strobes; with LSU_MISALIGN_CHECK_EN, lw addr 2 also faults; without it, lw addr 2 returns bytes 2..5.
- sw at addr 0; assert reset_n=0 during WRITE -> mem_write falls immediately, memory unchanged, no resp_valid, req_ready=1 after release.
